// File: rtl/uart_alici_pkg.sv
// Shared constants and helpers for the UART receiver and sibling peripherals.
package uart_alici_pkg;

    // Line levels: the serial line idles at HIGH, a start bit is LOW.
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int VERI_W  = 8;
    localparam int SAYAC_W = 16;

    // Index of the last data bit in an 8N1 frame.
    localparam logic [2:0] SON_BIT = 3'd7;

    // Counter value at which the middle of the start bit is reached.
    function automatic logic [SAYAC_W-1:0] yarim_bit(input logic [SAYAC_W-1:0] bolen);
        return (bolen >> 1) - {{(SAYAC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/uart_alici_if.sv
// Receive-side data handshake: byte out with valid/consume plus error pulses.
interface uart_alici_if;
    import uart_alici_pkg::*;

    logic [VERI_W-1:0] veri_o;
    logic              veri_gecerli_o;
    logic              consume_i;
    logic              cerceve_hatasi_o;
    logic              tasma_hatasi_o;

    // master: the receiver producing bytes; slave: the downstream consumer.
    modport master (
        output veri_o,
        output veri_gecerli_o,
        output cerceve_hatasi_o,
        output tasma_hatasi_o,
        input  consume_i
    );

    modport slave (
        input  veri_o,
        input  veri_gecerli_o,
        input  cerceve_hatasi_o,
        input  tasma_hatasi_o,
        output consume_i
    );
endinterface

// File: rtl/uart_alici_senkronlayici.sv
// Multi-stage flip-flop synchroniser for an asynchronous level input.
// Stages reset to 1 so an idle-high serial line shows no false edge.
module senkronlayici #(
    parameter int ASAMA = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [ASAMA-1:0] asama_reg;
    logic [ASAMA-1:0] asama_next;

    genvar gi;
    generate
        for (gi = 0; gi < ASAMA; gi++) begin : g_asama
            if (gi == 0) begin : g_ilk
                assign asama_next[gi] = d_i;
            end else begin : g_sonraki
                assign asama_next[gi] = asama_reg[gi-1];
            end
        end
    endgenerate

    // Shift the input through the stage chain every clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            asama_reg <= '1;
        end else begin
            asama_reg <= asama_next;
        end
    end

    assign q_o = asama_reg[ASAMA-1];

endmodule

// File: rtl/uart_alici.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling driven by a
// live baud divisor, one-byte holding register with consume handshake.
module uart_alici
    import uart_alici_pkg::*;
#(
    parameter int SENKRON_ASAMA = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_en_i,
    input  logic               rx_i,
    input  logic [SAYAC_W-1:0] baud_div_i,
    uart_alici_if.master       cikis
);

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        BASLA   = 2'd1,
        VERI_AL = 2'd2,
        BITTI   = 2'd3
    } durum_t;

    logic rx_s;

    durum_t              durum_reg,   durum_next;
    logic [SAYAC_W-1:0]  sayac_reg,   sayac_next;
    logic [2:0]          indeks_reg,  indeks_next;
    logic [VERI_W-1:0]   tampon_reg,  tampon_next;
    logic [VERI_W-1:0]   veri_reg,    veri_next;
    logic                gecerli_reg, gecerli_next;
    logic                cerceve_reg, cerceve_next;
    logic                tasma_reg,   tasma_next;

    logic [SAYAC_W-1:0]  bit_sonu;

    senkronlayici #(
        .ASAMA (SENKRON_ASAMA)
    ) u_senkron (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    assign bit_sonu = baud_div_i - {{(SAYAC_W-1){1'b0}}, 1'b1};

    // Register all receiver state; reset also clears a frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_reg   <= BOSTA;
            sayac_reg   <= '0;
            indeks_reg  <= '0;
            tampon_reg  <= '0;
            veri_reg    <= '0;
            gecerli_reg <= 1'b0;
            cerceve_reg <= 1'b0;
            tasma_reg   <= 1'b0;
        end else begin
            durum_reg   <= durum_next;
            sayac_reg   <= sayac_next;
            indeks_reg  <= indeks_next;
            tampon_reg  <= tampon_next;
            veri_reg    <= veri_next;
            gecerli_reg <= gecerli_next;
            cerceve_reg <= cerceve_next;
            tasma_reg   <= tasma_next;
        end
    end

    // Next-state, bit sampling and output handshake decisions.
    always_comb begin
        durum_next   = durum_reg;
        sayac_next   = sayac_reg + {{(SAYAC_W-1){1'b0}}, 1'b1};
        indeks_next  = indeks_reg;
        tampon_next  = tampon_reg;
        veri_next    = veri_reg;
        gecerli_next = gecerli_reg;
        cerceve_next = LOW;
        tasma_next   = LOW;

        // A consume frees the holding register; a completing byte below
        // may immediately refill it in the same cycle.
        if (gecerli_reg && cikis.consume_i) begin
            gecerli_next = 1'b0;
        end

        case (durum_reg)
            BOSTA: begin
                sayac_next = '0;
                // rx_en_i only gates new starts; frames in flight continue.
                if (rx_en_i && (rx_s == LOW)) begin
                    durum_next = BASLA;
                end
            end
            BASLA: begin
                if (sayac_reg == yarim_bit(baud_div_i)) begin
                    sayac_next  = '0;
                    indeks_next = '0;
                    // Line back high at mid start bit means a glitch.
                    durum_next  = (rx_s == LOW) ? VERI_AL : BOSTA;
                end
            end
            VERI_AL: begin
                if (sayac_reg == bit_sonu) begin
                    tampon_next[indeks_reg] = rx_s;
                    sayac_next  = '0;
                    indeks_next = indeks_reg + 3'd1;
                    if (indeks_reg == SON_BIT) begin
                        durum_next = BITTI;
                    end
                end
            end
            BITTI: begin
                if (sayac_reg == bit_sonu) begin
                    sayac_next = '0;
                    durum_next = BOSTA;
                    if (rx_s == HIGH) begin
                        if (!gecerli_reg || cikis.consume_i) begin
                            veri_next    = tampon_reg;
                            gecerli_next = 1'b1;
                        end else begin
                            tasma_next = HIGH;
                        end
                    end else begin
                        cerceve_next = HIGH;
                    end
                end
            end
            default: begin
                durum_next = BOSTA;
                sayac_next = '0;
            end
        endcase
    end

    assign cikis.veri_o           = veri_reg;
    assign cikis.veri_gecerli_o   = gecerli_reg;
    assign cikis.cerceve_hatasi_o = cerceve_reg;
    assign cikis.tasma_hatasi_o   = tasma_reg;

endmodule

// File: tb/tb_uart_alici.sv
// Scoreboard bench for uart_alici: stimulus pushes expected events with the
// cycle they must appear in; an independent monitor pops and compares.
module tb_uart_alici;

    typedef enum {OLAY_BAYT, OLAY_CERCEVE, OLAY_TASMA} olay_t;

    typedef struct {
        olay_t       tur;
        logic [7:0]  veri;
        int unsigned cyc;
    } beklenen_t;

    // Cycles from driving the start bit to the output being visible:
    // 2 sync + 1 detect + 8 half bit + 8*16 data + 16 stop-half.
    localparam int unsigned GECIKME = 155;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        rx_en_i;
    logic        rx_i;
    logic [15:0] baud_div_i;

    uart_alici_if u_if ();

    uart_alici #(
        .SENKRON_ASAMA (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_en_i    (rx_en_i),
        .rx_i       (rx_i),
        .baud_div_i (baud_div_i),
        .cikis      (u_if.master)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beklenen_t kuyruk[$];
    int checks = 0;
    int errors = 0;

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", ad, gercek, beklenen, cyc);
        end else begin
            $display("check %s = %0h ok (cyc %0d)", ad, gercek, cyc);
        end
    endtask

    task automatic olay_isle(input olay_t tur, input logic [7:0] veri);
        beklenen_t b;
        checks++;
        if (kuyruk.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s veri=%02h at cyc %0d, required no event",
                     tur.name(), veri, cyc);
        end else begin
            b = kuyruk.pop_front();
            if (b.tur != tur || (tur == OLAY_BAYT && b.veri !== veri) || b.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %s veri=%02h cyc=%0d, required %s veri=%02h cyc=%0d",
                         tur.name(), veri, cyc, b.tur.name(), b.veri, b.cyc);
            end else begin
                $display("event %s veri=%02h cyc=%0d ok", tur.name(), veri, cyc);
            end
        end
    endtask

    // Monitor: detect output events away from the active edge.
    logic prev_gecerli = 1'b0;
    logic prev_consume = 1'b0;
    logic prev_cerceve = 1'b0;
    logic prev_tasma   = 1'b0;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (u_if.veri_gecerli_o && (!prev_gecerli || prev_consume))
                olay_isle(OLAY_BAYT, u_if.veri_o);
            if (u_if.cerceve_hatasi_o && !prev_cerceve)
                olay_isle(OLAY_CERCEVE, 8'h00);
            if (u_if.tasma_hatasi_o && !prev_tasma)
                olay_isle(OLAY_TASMA, 8'h00);
            if (prev_cerceve)
                kontrol("cerceve_pulse_width", {31'd0, u_if.cerceve_hatasi_o}, 32'd0);
            if (prev_tasma)
                kontrol("tasma_pulse_width", {31'd0, u_if.tasma_hatasi_o}, 32'd0);
        end
        prev_gecerli = u_if.veri_gecerli_o;
        prev_consume = u_if.consume_i;
        prev_cerceve = u_if.cerceve_hatasi_o;
        prev_tasma   = u_if.tasma_hatasi_o;
    end

    task automatic bosta(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one 8N1 frame, 16 cycles per bit; optionally register the
    // expected resulting event GECIKME cycles after the start bit.
    task automatic cerceve_gonder(input logic [7:0] b, input logic stop,
                                  input logic beklenti_var, input olay_t tur,
                                  input logic [7:0] bveri);
        beklenen_t e;
        @(posedge clk);
        #1;
        rx_i = 1'b0;
        $display("tx frame %02h stop=%0b at cyc %0d", b, stop, cyc);
        if (beklenti_var) begin
            e.tur  = tur;
            e.veri = bveri;
            e.cyc  = cyc + GECIKME;
            kuyruk.push_back(e);
        end
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_i = b[i];
            repeat (16) @(posedge clk);
        end
        #1 rx_i = stop;
        repeat (16) @(posedge clk);
        #1 rx_i = 1'b1;
    endtask

    task automatic consume_darbe();
        @(posedge clk);
        #1 u_if.consume_i = 1'b1;
        @(posedge clk);
        #1 u_if.consume_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i          = 1'b1;
        rx_i           = 1'b1;
        rx_en_i        = 1'b1;
        baud_div_i     = 16'd16;
        u_if.consume_i = 1'b0;
        bosta(3);
        kontrol("reset_veri",    {24'd0, u_if.veri_o}, 32'h0);
        kontrol("reset_gecerli", {31'd0, u_if.veri_gecerli_o}, 32'h0);
        kontrol("reset_cerceve", {31'd0, u_if.cerceve_hatasi_o}, 32'h0);
        kontrol("reset_tasma",   {31'd0, u_if.tasma_hatasi_o}, 32'h0);
        rst_i = 1'b0;
        bosta(5);

        // Normal frame, held until consumed.
        cerceve_gonder(8'hA5, 1'b1, 1'b1, OLAY_BAYT, 8'hA5);
        bosta(20);
        kontrol("a5_held_gecerli", {31'd0, u_if.veri_gecerli_o}, 32'h1);
        kontrol("a5_held_veri",    {24'd0, u_if.veri_o}, 32'hA5);
        consume_darbe();
        kontrol("a5_consumed", {31'd0, u_if.veri_gecerli_o}, 32'h0);

        // False start: 4-cycle low glitch.
        @(posedge clk);
        #1 rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_i = 1'b1;
        bosta(30);
        kontrol("false_start_gecerli", {31'd0, u_if.veri_gecerli_o}, 32'h0);

        // Framing error.
        cerceve_gonder(8'h3C, 1'b0, 1'b1, OLAY_CERCEVE, 8'h00);
        bosta(20);
        kontrol("frame_err_gecerli", {31'd0, u_if.veri_gecerli_o}, 32'h0);

        // Overrun: second byte dropped while first is held.
        cerceve_gonder(8'h11, 1'b1, 1'b1, OLAY_BAYT, 8'h11);
        bosta(20);
        cerceve_gonder(8'h22, 1'b1, 1'b1, OLAY_TASMA, 8'h00);
        bosta(20);
        kontrol("overrun_veri",    {24'd0, u_if.veri_o}, 32'h11);
        kontrol("overrun_gecerli", {31'd0, u_if.veri_gecerli_o}, 32'h1);
        consume_darbe();
        kontrol("overrun_consumed", {31'd0, u_if.veri_gecerli_o}, 32'h0);

        // Consume exactly in the stop-sample cycle of the second byte.
        cerceve_gonder(8'h11, 1'b1, 1'b1, OLAY_BAYT, 8'h11);
        bosta(20);
        fork
            cerceve_gonder(8'h22, 1'b1, 1'b1, OLAY_BAYT, 8'h22);
            begin
                @(posedge clk);
                repeat (GECIKME - 1) @(posedge clk);
                #1 u_if.consume_i = 1'b1;
                @(posedge clk);
                #1 u_if.consume_i = 1'b0;
            end
        join
        bosta(20);
        kontrol("same_cycle_veri",    {24'd0, u_if.veri_o}, 32'h22);
        kontrol("same_cycle_gecerli", {31'd0, u_if.veri_gecerli_o}, 32'h1);
        consume_darbe();
        kontrol("same_cycle_consumed", {31'd0, u_if.veri_gecerli_o}, 32'h0);

        // Reset during data bit 3; the rest of the frame is all ones.
        fork
            cerceve_gonder(8'hF8, 1'b1, 1'b0, OLAY_BAYT, 8'h00);
            begin
                @(posedge clk);
                repeat (71) @(posedge clk);
                #1 rst_i = 1'b1;
                @(posedge clk);
                #1 rst_i = 1'b0;
                kontrol("midreset_veri",    {24'd0, u_if.veri_o}, 32'h0);
                kontrol("midreset_gecerli", {31'd0, u_if.veri_gecerli_o}, 32'h0);
                kontrol("midreset_cerceve", {31'd0, u_if.cerceve_hatasi_o}, 32'h0);
                kontrol("midreset_tasma",   {31'd0, u_if.tasma_hatasi_o}, 32'h0);
            end
        join
        bosta(20);
        cerceve_gonder(8'h5A, 1'b1, 1'b1, OLAY_BAYT, 8'h5A);
        bosta(20);
        kontrol("after_reset_veri", {24'd0, u_if.veri_o}, 32'h5A);
        consume_darbe();
        kontrol("after_reset_consumed", {31'd0, u_if.veri_gecerli_o}, 32'h0);

        bosta(10);
        kontrol("pending_expected_events", kuyruk.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
